// File: rtl/adder_share_arb_pkg.sv
// Shared definitions for the round-robin adder-sharing block: sizing
// constants, the id-width helper and the registered result record.
package adder_share_arb_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int NIBBLE_W        = 4;

  // Widest requester index ever stored; eight requesters is the upper limit.
  localparam int MAX_ID_W        = 3;

  // Number of bits needed to index n items, never less than one.
  function automatic int idWidth(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // One completed addition as it sits in the output register.
  typedef struct packed {
    logic                carry;
    logic [NIBBLE_W-1:0] sum;
    logic [MAX_ID_W-1:0] id;
  } result_t;

endpackage

// File: rtl/adder_share_arb_rr_pick.sv
// Combinational round-robin picker: rotates the request vector so the
// pointer position sits at bit 0, takes the lowest set bit, then rotates
// the winning position back into absolute requester numbering.
module adder_rr_pick
  import adder_share_arb_pkg::*;
#(
  parameter int N     = DEFAULT_NUM_REQ,
  parameter int PTR_W = idWidth(DEFAULT_NUM_REQ)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx
);

  logic [2*N-1:0]  w_dbl;
  logic [N-1:0]    w_rot;
  logic [PTR_W:0]  w_pos;
  logic            w_found;
  logic [PTR_W-1:0] w_idx;

  // Rotate, find the first requester at or after the pointer, rotate back.
  always_comb begin
    w_dbl   = {i_req, i_req} >> i_ptr;
    w_rot   = w_dbl[N-1:0] & {N{i_en}};
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_pos   = {1'b0, i_ptr} + (PTR_W+1)'(k);
      end
    end
    if (w_pos >= (PTR_W+1)'(N)) begin
      w_pos = w_pos - (PTR_W+1)'(N);
    end
    w_idx = w_pos[PTR_W-1:0];
    o_gnt = '0;
    if (w_found) begin
      o_gnt[w_idx] = 1'b1;
    end
  end

  assign o_idx = w_idx;

endmodule

// File: rtl/bit4_adder.sv
// Plain 4-bit adder with carry-out and no carry-in; this is the single
// arithmetic resource that the requesters take turns using.
module bit4_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_arb.sv
// Shares one 4-bit adder between NUM_REQ requesters. One add is accepted
// per cycle in round-robin order, the result lands in a single registered
// slot tagged with the owner's index, and the slot drains under
// valid/ready backpressure.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NIBBLE_W*NUM_REQ-1:0] req_a,
  input  logic [NIBBLE_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  output logic [NIBBLE_W-1:0]       res_sum,
  output logic                      res_carry,
  output logic [ID_W-1:0]           res_id,
  input  logic                      res_ready,
  output logic [CNT_W-1:0]          op_count
);

  logic                w_canAccept;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gntIdx;
  logic                w_anyGnt;
  logic [ID_W-1:0]     w_ptrNext;
  logic [NIBBLE_W-1:0] w_a;
  logic [NIBBLE_W-1:0] w_b;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_carry;

  result_t             r_res;
  logic                r_resValid;
  logic [CNT_W-1:0]    r_opCount;
  logic [ID_W-1:0]     r_ptr;

  // The slot can take a new result if it is empty or is being drained now.
  assign w_canAccept = !r_resValid || res_ready;

  adder_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_canAccept),
    .o_gnt (w_gnt),
    .o_idx (w_gntIdx)
  );

  assign w_anyGnt  = |w_gnt;
  assign req_ready = w_gnt;

  // The grant index selects the winner's operand nibbles.
  assign w_a = req_a[NIBBLE_W*w_gntIdx +: NIBBLE_W];
  assign w_b = req_b[NIBBLE_W*w_gntIdx +: NIBBLE_W];

  bit4_adder u_adder (
    .a     (w_a),
    .b     (w_b),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // Priority moves to the requester just after the one granted, wrapping.
  always_comb begin
    w_ptrNext = w_gntIdx + 1'b1;
    if (w_gntIdx == ID_W'(NUM_REQ-1)) begin
      w_ptrNext = '0;
    end
  end

  // Result slot, drain counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res      <= '0;
      r_resValid <= 1'b0;
      r_opCount  <= '0;
      r_ptr      <= '0;
    end else begin
      if (r_resValid && res_ready) begin
        r_opCount <= r_opCount + 1'b1;
      end
      if (w_anyGnt) begin
        r_res.carry <= w_carry;
        r_res.sum   <= w_sum;
        r_res.id    <= MAX_ID_W'(w_gntIdx);
        r_resValid  <= 1'b1;
        r_ptr       <= w_ptrNext;
      end else if (res_ready) begin
        r_resValid  <= 1'b0;
      end
    end
  end

  assign res_valid = r_resValid;
  assign res_sum   = r_res.sum;
  assign res_carry = r_res.carry;
  assign res_id    = ID_W'(r_res.id);
  assign op_count  = r_opCount;

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed scenarios plus a randomized run, all
// compared against a behavioural model of the arbiter and result slot.
module tb_adder_share_arb;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        res_ready = 1'b0;

  logic [3:0]  req_ready, req_ready4;
  logic        res_valid, res_valid4;
  logic [3:0]  res_sum, res_sum4;
  logic        res_carry, res_carry4;
  logic [1:0]  res_id, res_id4;
  logic [15:0] op_count;
  logic [3:0]  op_count4;

  int checks = 0;
  int failures = 0;

  // Model state: rr pointer, pending result, total drained results.
  int mPtr = 0;
  bit mValid = 0;
  int mTotal = 0;
  int mId = 0;
  int mCount = 0;

  adder_share_arb #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_sum(res_sum),
    .res_carry(res_carry), .res_id(res_id), .res_ready(res_ready), .op_count(op_count)
  );

  adder_share_arb #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready4), .res_valid(res_valid4), .res_sum(res_sum4),
    .res_carry(res_carry4), .res_id(res_id4), .res_ready(res_ready), .op_count(op_count4)
  );

  always #5 clk = ~clk;

  // Expected grant: first valid requester searching from the pointer.
  function automatic logic [3:0] expReady();
    int i;
    if (mValid && !res_ready) return 4'b0000;
    for (int k = 0; k < N; k++) begin
      i = (mPtr + k) % N;
      if (req_valid[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  // Advance one clock and the model along with it; returns #1 after the edge.
  task automatic tick();
    logic [3:0] er;
    int g;
    er = expReady();
    g = 0;
    for (int k = 0; k < N; k++) if (er[k]) g = k;
    @(posedge clk);
    if (mValid && res_ready) mCount++;
    if (er != 4'b0000) begin
      mTotal = int'(req_a[4*g +: 4]) + int'(req_b[4*g +: 4]);
      mId    = g;
      mValid = 1;
      mPtr   = (g + 1) % N;
    end else if (res_ready) begin
      mValid = 0;
    end
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    mPtr = 0; mValid = 0; mCount = 0; mTotal = 0; mId = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    resetDut();
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || res_valid !== 1'b0 || op_count !== 16'd0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: got ready=%b valid=%b count=%0d, want 0000/0/0",
                 c, req_ready, res_valid, op_count);
      end
      tick();
    end
  endtask

  task automatic test_single();
    resetDut();
    res_ready = 1'b1;
    req_valid = 4'b0100;
    req_a = 16'h0900;
    req_b = 16'h0800;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 4'd1 || res_carry !== 1'b1 || res_id !== 2'd2) begin
      failures++;
      $display("FAIL single_result: got v=%b sum=%0d c=%b id=%0d want 1/1/1/2",
               res_valid, res_sum, res_carry, res_id);
    end
    tick();
    checks++;
    if (op_count !== 16'd1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_count: got count=%0d v=%b want 1/0", op_count, res_valid);
    end
  endtask

  task automatic test_round_robin();
    resetDut();
    res_ready = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      #1;
      checks++;
      if (req_ready !== 4'(1 << (i % 4)) || req_ready !== expReady()) begin
        failures++;
        $display("FAIL rr_grant %0d: got %b want %b", i, req_ready, 4'(1 << (i % 4)));
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || int'(res_id) != (i % 4) || {res_carry, res_sum} !== 5'(mTotal)) begin
        failures++;
        $display("FAIL rr_result %0d: got v=%b id=%0d val=%0d want 1/%0d/%0d",
                 i, res_valid, res_id, {res_carry, res_sum}, i % 4, mTotal);
      end
    end
    req_valid = '0;
    tick();
    checks++;
    if (op_count !== 16'd8) begin
      failures++;
      $display("FAIL rr_count: got %0d want 8", op_count);
    end
  endtask

  task automatic test_stall();
    resetDut();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    req_a = 16'h000F;
    req_b = 16'h000F;
    #1;
    tick();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL stall_ready %0d: got %b want 0000", c, req_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_sum !== 4'd14 || res_carry !== 1'b1 || res_id !== 2'd0) begin
        failures++;
        $display("FAIL stall_hold %0d: got v=%b sum=%0d c=%b id=%0d want 1/14/1/0",
                 c, res_valid, res_sum, res_carry, res_id);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL stall_release_ready: got %b want 0010", req_ready);
    end
    tick();
    checks++;
    if (op_count !== 16'd1 || res_valid !== 1'b1 || res_id !== 2'd1 || {res_carry, res_sum} !== 5'(mTotal)) begin
      failures++;
      $display("FAIL stall_drain_load: got count=%0d v=%b id=%0d val=%0d want 1/1/1/%0d",
               op_count, res_valid, res_id, {res_carry, res_sum}, mTotal);
    end
  endtask

  task automatic test_async_reset();
    resetDut();
    res_ready = 1'b1;
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      #1;
      tick();
    end
    res_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || op_count !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: got v=%b count=%0d want 0/0", res_valid, op_count);
    end
    mPtr = 0; mValid = 0; mCount = 0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL async_restart_ready: got %b want 0010", req_ready);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1) begin
      failures++;
      $display("FAIL async_restart_id: got v=%b id=%0d want 1/1", res_valid, res_id);
    end
  endtask

  task automatic test_wrap();
    resetDut();
    res_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      req_valid = 4'(1 << $urandom_range(0, 3));
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      #1;
      tick();
    end
    req_valid = '0;
    tick();
    checks++;
    if (op_count4 !== 4'd1 || op_count !== 16'd17) begin
      failures++;
      $display("FAIL count_wrap: got narrow=%0d wide=%0d want 1/17", op_count4, op_count);
    end
  endtask

  task automatic test_random();
    resetDut();
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom);
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (req_ready !== expReady()) begin
        failures++;
        $display("FAIL rand_ready %0d: got %b want %b", c, req_ready, expReady());
      end
      tick();
      checks++;
      if (res_valid !== mValid || op_count !== 16'(mCount) || op_count4 !== 4'(mCount)) begin
        failures++;
        $display("FAIL rand_state %0d: got v=%b count=%0d/%0d want %b/%0d",
                 c, res_valid, op_count, op_count4, mValid, mCount);
      end
      if (mValid) begin
        checks++;
        if ({res_carry, res_sum} !== 5'(mTotal) || int'(res_id) != mId) begin
          failures++;
          $display("FAIL rand_result %0d: got val=%0d id=%0d want %0d/%0d",
                   c, {res_carry, res_sum}, res_id, mTotal, mId);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
